// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: parses UART score-set/clear frames into two BCD scores with K/E replies
module uart_cmd_parser #(
    parameter int TIMEOUT = 50000000,
    parameter int TO_W    = 26
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic [7:0] RX_DATA,
    input  logic       RX_VALID,
    input  logic       TX_READY,
    output logic [7:0] TX_DATA,
    output logic       TX_WR,
    output logic [7:0] SCORE_A,
    output logic [7:0] SCORE_B,
    output logic       UPDATE,
    output logic [7:0] ERR_CNT
);
    typedef enum logic [2:0] {IDLE, TEAM, DIG_HI, DIG_LO, TERM, CLR_TERM, RESP} state_t;

    state_t          state, state_n;
    logic            team_b, team_b_n;
    logic [3:0]      hi, hi_n, lo, lo_n;
    logic [7:0]      resp, resp_n;
    logic [TO_W-1:0] to_cnt;
    logic            active, active_n, is_digit, timeout;
    logic            bad, err_inc, commit, clr, tx_fire;

    assign active   = state inside {TEAM, DIG_HI, DIG_LO, TERM, CLR_TERM};
    assign active_n = state_n inside {TEAM, DIG_HI, DIG_LO, TERM, CLR_TERM};
    assign is_digit = RX_DATA >= 8'h30 && RX_DATA <= 8'h39;
    assign timeout  = active && !RX_VALID && to_cnt == TO_W'(TIMEOUT - 1);

    // Next-state decode: byte classification per frame position, timeout abandon, reply hand-off
    always_comb begin
        state_n  = state;
        team_b_n = team_b;
        hi_n     = hi;
        lo_n     = lo;
        resp_n   = resp;
        bad      = 1'b0;
        err_inc  = 1'b0;
        commit   = 1'b0;
        clr      = 1'b0;
        tx_fire  = 1'b0;
        if (timeout) begin
            state_n = IDLE;
            err_inc = 1'b1;
        end else if (RX_VALID) begin
            case (state)
                IDLE: state_n = RX_DATA == 8'h53 ? TEAM : RX_DATA == 8'h52 ? CLR_TERM : IDLE;
                TEAM: begin
                    bad      = RX_DATA != 8'h41 && RX_DATA != 8'h42;
                    team_b_n = RX_DATA == 8'h42;
                    state_n  = DIG_HI;
                end
                DIG_HI: begin
                    bad     = !is_digit;
                    hi_n    = RX_DATA[3:0];
                    state_n = DIG_LO;
                end
                DIG_LO: begin
                    bad     = !is_digit;
                    lo_n    = RX_DATA[3:0];
                    state_n = TERM;
                end
                TERM: begin
                    bad     = RX_DATA != 8'h0D;
                    commit  = !bad;
                    resp_n  = 8'h4B;
                    state_n = RESP;
                end
                CLR_TERM: begin
                    bad     = RX_DATA != 8'h0D;
                    clr     = !bad;
                    resp_n  = 8'h4B;
                    state_n = RESP;
                end
                RESP: err_inc = 1'b1;
                default: state_n = IDLE;
            endcase
            if (bad) begin
                state_n = RESP;
                resp_n  = 8'h45;
                err_inc = 1'b1;
            end
        end
        if (state == RESP && TX_READY) begin
            tx_fire = 1'b1;
            state_n = IDLE;
        end
    end

    // State register
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_n;
    end

    // Datapath: frame latches, gap timer, scores, reply strobe and error counter
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            team_b  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            resp    <= '0;
            to_cnt  <= '0;
            SCORE_A <= '0;
            SCORE_B <= '0;
            UPDATE  <= 1'b0;
            TX_WR   <= 1'b0;
            TX_DATA <= '0;
            ERR_CNT <= '0;
        end else begin
            team_b  <= team_b_n;
            hi      <= hi_n;
            lo      <= lo_n;
            resp    <= resp_n;
            to_cnt  <= (RX_VALID || !active_n) ? '0 : to_cnt + TO_W'(1);
            UPDATE  <= commit || clr;
            TX_WR   <= tx_fire;
            if (commit && !team_b) SCORE_A <= {hi, lo};
            if (commit && team_b)  SCORE_B <= {hi, lo};
            if (clr) begin
                SCORE_A <= '0;
                SCORE_B <= '0;
            end
            if (tx_fire) TX_DATA <= resp;
            if (err_inc && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
        end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: randomized self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_data, score_a, score_b, err_cnt;
    logic       tx_wr, update;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] txq[$];
    int         upd_cnt = 0;
    logic [7:0] exp_a = '0;
    logic [7:0] exp_b = '0;
    int         exp_err = 0;

    uart_cmd_parser #(.TIMEOUT(16), .TO_W(8)) dut (
        .CLK_50MHZ(clk),
        .RST(rst_n),
        .RX_DATA(rx_data),
        .RX_VALID(rx_valid),
        .TX_READY(tx_ready),
        .TX_DATA(tx_data),
        .TX_WR(tx_wr),
        .SCORE_A(score_a),
        .SCORE_B(score_b),
        .UPDATE(update),
        .ERR_CNT(err_cnt)
    );

    always #5 clk = ~clk;

    // Record every reply byte and every UPDATE pulse
    always @(negedge clk) begin
        if (tx_wr) txq.push_back(tx_data);
        if (update) upd_cnt++;
    end

    function automatic logic [7:0] sat_err();
        return exp_err > 255 ? 8'hFF : 8'(exp_err);
    endfunction

    function automatic bit in_class(input bit is_clr, input int pos, input logic [7:0] b);
        if (is_clr || pos == 4) return b == 8'h0D;
        if (pos == 1) return b == 8'h41 || b == 8'h42;
        return b >= 8'h30 && b <= 8'h39;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tx(input int n);
        for (int k = 0; k < 50 && txq.size() < n; k++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4, input int gap);
        send_byte(b0); idle(gap);
        send_byte(b1); idle(gap);
        send_byte(b2); idle(gap);
        send_byte(b3); idle(gap);
        send_byte(b4);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        checks++;
        if ({tx_data, tx_wr, score_a, score_b, update, err_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: tx_data=%h tx_wr=%b a=%h b=%h upd=%b err=%0d, required all zero",
                     tx_data, tx_wr, score_a, score_b, update, err_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_set_a();
        int base = txq.size();
        send_byte(8'h53); send_byte(8'h41); send_byte(8'h30); send_byte(8'h37); send_byte(8'h0D);
        exp_a = 8'h07;
        checks++;
        if (update !== 1'b1 || score_a !== exp_a || tx_wr !== 1'b0) begin
            errors++;
            $display("FAIL set_a_commit: upd=%b a=%h tx_wr=%b, required upd=1 a=%h tx_wr=0", update, score_a, tx_wr, exp_a);
        end
        @(negedge clk);
        checks++;
        if (tx_wr !== 1'b1 || tx_data !== 8'h4B || update !== 1'b0) begin
            errors++;
            $display("FAIL set_a_reply: tx_wr=%b tx_data=%h upd=%b, required 1 4b 0", tx_wr, tx_data, update);
        end
        idle(3);
        #1;
        checks++;
        if (tx_wr !== 1'b0 || tx_data !== 8'h4B || txq.size() != base + 1 || upd_cnt != 1 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL set_a_after: tx_wr=%b tx_data=%h replies=%0d upd_cnt=%0d err=%0d, required 0 4b %0d 1 0",
                     tx_wr, tx_data, txq.size(), upd_cnt, err_cnt, base + 1);
        end
    endtask

    task automatic test_set_clear();
        int base = txq.size();
        int ub = upd_cnt;
        send_frame(8'h53, 8'h42, 8'h39, 8'h39, 8'h0D, 0);
        wait_tx(base + 1);
        exp_b = 8'h99;
        checks++;
        if (score_b !== exp_b || score_a !== exp_a) begin
            errors++;
            $display("FAIL set_b_99: a=%h b=%h, required a=%h b=%h", score_a, score_b, exp_a, exp_b);
        end
        send_byte(8'h52); send_byte(8'h0D);
        wait_tx(base + 2);
        exp_a = 8'h00;
        exp_b = 8'h00;
        checks++;
        if (score_a !== 8'h00 || score_b !== 8'h00 || txq.size() != base + 2 || upd_cnt - ub != 2) begin
            errors++;
            $display("FAIL clear: a=%h b=%h replies=%0d upd=%0d, required 00 00 %0d 2", score_a, score_b,
                     txq.size(), upd_cnt - ub, base + 2);
        end else begin
            checks++;
            if (txq[base] !== 8'h4B || txq[base + 1] !== 8'h4B) begin
                errors++;
                $display("FAIL clear_replies: got %h %h, required 4b 4b", txq[base], txq[base + 1]);
            end
        end
    endtask

    task automatic test_bad_team();
        int base = txq.size();
        send_byte(8'h53); send_byte(8'h43);
        wait_tx(base + 1);
        exp_err++;
        checks++;
        if (txq.size() != base + 1 || err_cnt !== sat_err() || score_a !== exp_a || score_b !== exp_b) begin
            errors++;
            $display("FAIL bad_team: replies=%0d err=%0d a=%h b=%h, required %0d %0d %h %h",
                     txq.size(), err_cnt, score_a, score_b, base + 1, sat_err(), exp_a, exp_b);
        end else begin
            checks++;
            if (txq[base] !== 8'h45) begin
                errors++;
                $display("FAIL bad_team_reply: got %h, required 45", txq[base]);
            end
        end
        send_frame(8'h53, 8'h41, 8'h31, 8'h32, 8'h0D, 0);
        wait_tx(base + 2);
        exp_a = 8'h12;
        checks++;
        if (score_a !== exp_a || txq.size() != base + 2 || txq[$] !== 8'h4B) begin
            errors++;
            $display("FAIL after_bad_team: a=%h replies=%0d, required a=%h replies=%0d last=4b", score_a, txq.size(), exp_a, base + 2);
        end
    endtask

    task automatic test_timeout();
        int base = txq.size();
        send_byte(8'h53); send_byte(8'h41);
        idle(20);
        #1;
        exp_err++;
        checks++;
        if (txq.size() != base || err_cnt !== sat_err()) begin
            errors++;
            $display("FAIL timeout: replies=%0d err=%0d, required %0d %0d", txq.size(), err_cnt, base, sat_err());
        end
        send_frame(8'h53, 8'h42, 8'h34, 8'h32, 8'h0D, 0);
        wait_tx(base + 1);
        exp_b = 8'h42;
        checks++;
        if (score_b !== exp_b || txq.size() != base + 1) begin
            errors++;
            $display("FAIL after_timeout: b=%h replies=%0d, required %h %0d", score_b, txq.size(), exp_b, base + 1);
        end
        send_frame(8'h53, 8'h41, 8'h35, 8'h36, 8'h0D, 14);
        wait_tx(base + 2);
        exp_a = 8'h56;
        checks++;
        if (score_a !== exp_a || txq.size() != base + 2 || err_cnt !== sat_err()) begin
            errors++;
            $display("FAIL gap_boundary: a=%h replies=%0d err=%0d, required %h %0d %0d",
                     score_a, txq.size(), err_cnt, exp_a, base + 2, sat_err());
        end
        send_byte(8'h53); idle(15); send_byte(8'h41);
        idle(20);
        #1;
        exp_err++;
        checks++;
        if (txq.size() != base + 2 || err_cnt !== sat_err() || score_a !== exp_a) begin
            errors++;
            $display("FAIL gap_exceeded: replies=%0d err=%0d a=%h, required %0d %0d %h",
                     txq.size(), err_cnt, score_a, base + 2, sat_err(), exp_a);
        end
    endtask

    task automatic test_backpressure();
        int base = txq.size();
        tx_ready = 1'b0;
        send_frame(8'h53, 8'h41, 8'h30, 8'h35, 8'h0D, 0);
        exp_a = 8'h05;
        idle(3);
        send_byte(8'h31);
        idle(5);
        #1;
        exp_err++;
        checks++;
        if (txq.size() != base || err_cnt !== sat_err() || score_a !== exp_a) begin
            errors++;
            $display("FAIL stall_drop: replies=%0d err=%0d a=%h, required %0d %0d %h", txq.size(), err_cnt, score_a, base, sat_err(), exp_a);
        end
        @(negedge clk);
        tx_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_wr !== 1'b1 || tx_data !== 8'h4B) begin
            errors++;
            $display("FAIL stall_release: tx_wr=%b tx_data=%h, required 1 4b", tx_wr, tx_data);
        end
        idle(5);
        #1;
        checks++;
        if (txq.size() != base + 1) begin
            errors++;
            $display("FAIL stall_single: replies=%0d, required %0d", txq.size(), base + 1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [7:0] f[$];
            logic [7:0] b, tm, exp_r;
            logic [3:0] h, l;
            bit         is_clr, ok;
            int         pos, base, ub;
            base   = txq.size();
            ub     = upd_cnt;
            is_clr = $urandom_range(0, 3) == 0;
            ok     = $urandom_range(0, 2) != 0;
            tm     = $urandom_range(0, 1) ? 8'h42 : 8'h41;
            h      = 4'($urandom_range(0, 9));
            l      = 4'($urandom_range(0, 9));
            f      = is_clr ? '{8'h52, 8'h0D} : '{8'h53, tm, {4'h3, h}, {4'h3, l}, 8'h0D};
            if (!ok) begin
                pos = $urandom_range(1, f.size() - 1);
                do b = 8'($urandom); while (in_class(is_clr, pos, b));
                f[pos] = b;
                while (f.size() > pos + 1) void'(f.pop_back());
            end
            repeat ($urandom_range(0, 2)) begin
                do b = 8'($urandom); while (b == 8'h53 || b == 8'h52);
                send_byte(b);
            end
            tx_ready = $urandom_range(0, 3) != 0;
            foreach (f[i]) send_byte(f[i]);
            idle($urandom_range(0, 4));
            tx_ready = 1'b1;
            wait_tx(base + 1);
            exp_r = ok ? 8'h4B : 8'h45;
            if (!ok) exp_err++;
            else if (is_clr) begin
                exp_a = 8'h00;
                exp_b = 8'h00;
            end else if (tm == 8'h42) exp_b = {h, l};
            else exp_a = {h, l};
            checks++;
            if (txq.size() != base + 1 || score_a !== exp_a || score_b !== exp_b || err_cnt !== sat_err() ||
                upd_cnt - ub != int'(ok)) begin
                errors++;
                $display("FAIL random_%0d: replies=%0d a=%h b=%h err=%0d upd=%0d, required %0d %h %h %0d %0d",
                         n, txq.size(), score_a, score_b, err_cnt, upd_cnt - ub, base + 1, exp_a, exp_b, sat_err(), int'(ok));
            end else begin
                checks++;
                if (txq[$] !== exp_r) begin
                    errors++;
                    $display("FAIL random_reply_%0d: got %h, required %h", n, txq[$], exp_r);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int base = txq.size();
        send_byte(8'h53); send_byte(8'h42); send_byte(8'h37);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_data, tx_wr, score_a, score_b, update, err_cnt} !== '0) begin
            errors++;
            $display("FAIL midframe_reset: tx_data=%h tx_wr=%b a=%h b=%h upd=%b err=%0d, required all zero",
                     tx_data, tx_wr, score_a, score_b, update, err_cnt);
        end
        exp_a = 8'h00;
        exp_b = 8'h00;
        exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        #1;
        checks++;
        if (txq.size() != base || score_a !== 8'h00 || score_b !== 8'h00) begin
            errors++;
            $display("FAIL no_reply_after_reset: replies=%0d a=%h b=%h, required %0d 00 00", txq.size(), score_a, score_b, base);
        end
        tx_ready = 1'b0;
        send_frame(8'h53, 8'h41, 8'h31, 8'h32, 8'h0D, 0);
        exp_a = 8'h12;
        repeat (300) begin
            send_byte(8'($urandom));
            exp_err++;
        end
        #1;
        checks++;
        if (err_cnt !== sat_err() || txq.size() != base) begin
            errors++;
            $display("FAIL err_saturate: err=%0d replies=%0d, required %0d %0d", err_cnt, txq.size(), sat_err(), base);
        end
        tx_ready = 1'b1;
        wait_tx(base + 1);
        checks++;
        if (txq.size() != base + 1 || score_a !== exp_a || err_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL sat_reply: replies=%0d a=%h err=%0d, required %0d %h 255", txq.size(), score_a, err_cnt, base + 1, exp_a);
        end else begin
            checks++;
            if (txq[$] !== 8'h4B) begin
                errors++;
                $display("FAIL sat_reply_byte: got %h, required 4b", txq[$]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_set_a();
        test_set_clear();
        test_bad_team();
        test_timeout();
        test_backpressure();
        test_random();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT, default 50000000, meaning the inter-byte gap in CLK_50MHZ cycles after which a partial frame is abandoned.
REQ-002 SHALL have parameter TO_W, default 26, meaning the timeout counter width.
REQ-003 CLK_50MHZ  input  1  sole clock; all logic on rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 RX_DATA  input  8  received byte from the UART RX path.
REQ-006 RX_VALID  input  1  one-cycle strobe; RX_DATA valid in that cycle.
REQ-007 TX_READY  input  1  UART TX path can accept a byte this cycle.
REQ-008 TX_DATA  output  8  response byte to the UART TX path.
REQ-009 TX_WR  output  1  one-cycle write strobe for TX_DATA.
REQ-010 SCORE_A  output  8  team A score, two BCD digits (tens in [7:4]).
REQ-011 SCORE_B  output  8  team B score, two BCD digits.
REQ-012 UPDATE  output  1  one-cycle strobe after SCORE_A or SCORE_B changes.
REQ-013 ERR_CNT  output  8  count of rejected frames and dropped bytes, saturating at 255.

Function
REQ-014 Frames: set = 'S'(0x53), team 'A'(0x41)/'B'(0x42), tens digit '0'-'9', units digit '0'-'9', CR(0x0D); clear = 'R'(0x52), CR.
REQ-015 FSM states SHALL be IDLE, TEAM, DIG_HI, DIG_LO, TERM, CLR_TERM, RESP.
REQ-016 IDLE: 'S' -> TEAM; 'R' -> CLR_TERM; any other byte ignored, no error.
REQ-017 TEAM: 'A'/'B' latched -> DIG_HI; DIG_HI: digit latched as RX_DATA-0x30 -> DIG_LO; DIG_LO: likewise -> TERM.
REQ-018 TERM: CR -> commit {hi,lo} to the selected score, response 'K'(0x4B), -> RESP.
REQ-019 CLR_TERM: CR -> SCORE_A=SCORE_B=0x00, response 'K', -> RESP.
REQ-020 Any byte that does not match the expected class in TEAM..CLR_TERM: discard partial frame, scores unchanged, response 'E'(0x45), ERR_CNT+1, -> RESP.
REQ-021 Score commit and UPDATE pulse SHALL occur in the cycle after the CR strobe; UPDATE is asserted even when the new value equals the old.
REQ-022 RESP: TX_WR asserted for exactly one cycle with TX_DATA = response, in the first cycle TX_READY=1 (earliest one cycle after entry), then -> IDLE next cycle.
REQ-023 TX_DATA SHALL hold its value from the TX_WR cycle until the next TX_WR.
REQ-024 RX_VALID while in RESP: byte dropped, ERR_CNT+1, no other effect.
REQ-025 Timeout counter SHALL clear on every RX_VALID and on entry to IDLE; in TEAM..CLR_TERM, reaching TIMEOUT-1 without RX_VALID -> IDLE silently, no response, ERR_CNT+1.
REQ-026 Timeout and RX_VALID in the same cycle: RX_VALID wins, byte processed normally.
REQ-027 Counter wrap not permitted: the timeout counter is idle in IDLE and RESP; ERR_CNT holds at 255.
REQ-028 Simultaneous ERR_CNT increment sources cannot occur in one cycle; one increment per cycle maximum.

Reset
REQ-029 RST low SHALL immediately force: state IDLE, SCORE_A=0x00, SCORE_B=0x00, ERR_CNT=0x00, TX_WR=0, TX_DATA=0x00, UPDATE=0, timeout counter 0, latched team/digits 0.
REQ-030 Reset mid-frame or mid-RESP SHALL abandon everything; a pending response is never sent.
REQ-031 Release of RST SHALL be honoured on the next rising edge; first byte accepted in the first cycle after release.

Verification
REQ-032 Bytes 53 41 30 37 0D, TX_READY=1 -> SCORE_A=0x07, UPDATE one pulse, TX_WR one pulse with 0x4B, ERR_CNT=0.
REQ-033 Bytes 53 42 39 39 0D then 52 0D -> SCORE_B=0x99, then both scores 0x00, two 'K' responses, two UPDATE pulses.
REQ-034 Bytes 53 43 -> 'E' sent, ERR_CNT=1, scores unchanged; following 53 41 31 32 0D -> SCORE_A=0x12.
REQ-035 TIMEOUT=16, bytes 53 41 then 20 idle cycles -> back to IDLE, no TX_WR, ERR_CNT=1; then full valid frame accepted.
REQ-036 TX_READY held low 10 cycles after CR, extra byte 0x31 strobed meanwhile -> byte dropped, ERR_CNT=1, single 'K' strobe in first cycle TX_READY=1.
REQ-037 RST low asserted between digit bytes of a frame -> all outputs zero immediately, no response after release; 300 spurious ERR events saturate ERR_CNT at 255.
